// File: rtl/pump_seq_pkg.sv
// rtl/pump_seq_pkg.sv - shared types and air-line patterns for the pump/valve sequencer
package pump_seq_pkg;

  typedef enum logic [2:0] {IDLE, OPEN_OUT, PUMP, CLOSE_OUT, DONE} state_t;

  typedef logic [2:0] phase_t;

  localparam phase_t LAST_PHASE = 3'd5;

  // Patterns are packed {v1, dc, v2}; 1 = pressurized (valve closed / chamber compressed)
  localparam logic [2:0] IDLE_PAT = 3'b101;
  localparam logic [2:0] PHASE_PAT [6] = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b111, 3'b101};

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter timing valve settle and pump phase intervals
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Loading L-1 makes the interval last exactly L cycles, expiring on the last one
  assign expire = (cnt == '0);

endmodule

// File: rtl/pump_valve_sequencer.sv
// rtl/pump_valve_sequencer.sv - opens output valve, runs N peristaltic strokes, closes valve
module pump_valve_sequencer
  import pump_seq_pkg::*;
#(
  parameter int DWELL    = 4,
  parameter int SETTLE   = 8,
  parameter int STROKE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [STROKE_W-1:0] strokes,
  input  logic                abort,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [STROKE_W-1:0] stroke_cnt,
  output logic                out_air_valve1,
  output logic                out_air_dc,
  output logic                out_air_valve2,
  output logic                out_air
);

  localparam int MAXV = (DWELL > SETTLE) ? DWELL : SETTLE;
  localparam int TW   = $clog2(MAXV + 1);
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE - 1);
  localparam logic [TW-1:0] DWELL_LD  = TW'(DWELL - 1);

  state_t                state;
  phase_t                phase;
  phase_t                next_phase;
  logic [STROKE_W-1:0]   strokes_q;
  logic                  last_stroke;
  logic                  tmr_load;
  logic [TW-1:0]         tmr_value;
  logic                  expire;

  assign next_phase  = phase + 3'd1;
  assign last_stroke = ((stroke_cnt + STROKE_W'(1)) == strokes_q);

  // Timer reload mirrors every state/phase transition taken by the FSM below
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = SETTLE_LD;
    case (state)
      IDLE: begin
        tmr_load = start && (strokes != '0);
      end
      OPEN_OUT: begin
        tmr_load = abort || expire;
        if (!abort) tmr_value = DWELL_LD;
      end
      PUMP: begin
        tmr_load = abort || expire;
        if (!abort && !(phase == LAST_PHASE && last_stroke)) tmr_value = DWELL_LD;
      end
      default: ;
    endcase
  end

  phase_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      strokes_q  <= '0;
      stroke_cnt <= '0;
      {out_air_valve1, out_air_dc, out_air_valve2} <= IDLE_PAT;
      out_air    <= 1'b1;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            strokes_q  <= strokes;
            stroke_cnt <= '0;
            aborted    <= 1'b0;
            ready      <= 1'b0;
            if (strokes == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= OPEN_OUT;
              busy    <= 1'b1;
              out_air <= 1'b0;
            end
          end
        end
        OPEN_OUT: begin
          if (abort) begin
            state   <= CLOSE_OUT;
            out_air <= 1'b1;
            aborted <= 1'b1;
          end else if (expire) begin
            state <= PUMP;
            phase <= '0;
            {out_air_valve1, out_air_dc, out_air_valve2} <= PHASE_PAT[0];
          end
        end
        PUMP: begin
          // A stroke whose final ph5 cycle coincides with abort is still complete
          if (expire && phase == LAST_PHASE) stroke_cnt <= stroke_cnt + STROKE_W'(1);
          if (abort || (expire && phase == LAST_PHASE && last_stroke)) begin
            state   <= CLOSE_OUT;
            out_air <= 1'b1;
            {out_air_valve1, out_air_dc, out_air_valve2} <= IDLE_PAT;
            if (abort) aborted <= 1'b1;
          end else if (expire) begin
            if (phase == LAST_PHASE) begin
              phase <= '0;
              {out_air_valve1, out_air_dc, out_air_valve2} <= PHASE_PAT[0];
            end else begin
              phase <= next_phase;
              {out_air_valve1, out_air_dc, out_air_valve2} <= PHASE_PAT[next_phase];
            end
          end
        end
        CLOSE_OUT: begin
          if (expire) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pump_valve_sequencer.sv
// tb/tb_pump_valve_sequencer.sv - randomized bench against a timeline model of the sequencer
module tb_pump_valve_sequencer;

  localparam int D  = 2;
  localparam int S  = 3;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [SW-1:0] strokes;
  logic          abort;
  logic          ready, busy, done, aborted;
  logic [SW-1:0] stroke_cnt;
  logic          v1, dc, v2, out_air;

  int n_total = 0;
  int n_bad   = 0;

  logic [2:0] pat_tab [6] = '{3'b001, 3'b101, 3'b100, 3'b110, 3'b111, 3'b101};
  logic [7:0] idle_lines = 8'b1011_1000;

  always #5 clk = ~clk;

  pump_valve_sequencer #(.DWELL(D), .SETTLE(S), .STROKE_W(SW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .strokes        (strokes),
    .abort          (abort),
    .ready          (ready),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .stroke_cnt     (stroke_cnt),
    .out_air_valve1 (v1),
    .out_air_dc     (dc),
    .out_air_valve2 (v2),
    .out_air        (out_air)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lines_now();
    return {v1, dc, v2, out_air, ready, busy, done, aborted};
  endfunction

  // Expected {v1,dc,v2,out_air,ready,busy,done,aborted} k cycles after start accepted; a=0 means no abort
  function automatic logic [7:0] model_lines(int k, int n, int a);
    int tend = S + 6 * D * n;
    bit ab = (n != 0) && (a > 0);
    int c = ab ? a + 1 : tend + 1;
    logic [2:0] p = 3'b101;
    logic air = 1'b1, rdy = 1'b0, bsy = 1'b0, dn = 1'b0, abd = 1'b0;
    if (n == 0) begin
      if (k == 1) dn = 1'b1;
      else rdy = 1'b1;
    end else if (k < c) begin
      air = 1'b0;
      bsy = 1'b1;
      if (k > S) p = pat_tab[((k - S - 1) / D) % 6];
    end else if (k < c + S) begin
      bsy = 1'b1;
      abd = ab;
    end else if (k == c + S) begin
      dn  = 1'b1;
      abd = ab;
    end else begin
      rdy = 1'b1;
      abd = ab;
    end
    return {p, air, rdy, bsy, dn, abd};
  endfunction

  function automatic int model_cnt(int k, int n, int a);
    int lim = k - 1;
    int c;
    if (n == 0) return 0;
    if (a > 0 && a < lim) lim = a;
    if (lim < S) return 0;
    c = (lim - S) / (6 * D);
    return (c > n) ? n : c;
  endfunction

  // One full run: accept at cycle 0, check every cycle until back in IDLE
  task automatic run(input int n, input int a);
    int tend = S + 6 * D * n;
    int c = (n != 0 && a > 0) ? a + 1 : tend + 1;
    int last_k = (n == 0) ? 2 : c + S + 1;
    @(negedge clk);
    check("ready_before_start", {31'd0, ready}, 32'd1);
    start   = 1'b1;
    strokes = SW'(n);
    abort   = 1'($urandom_range(0, 1));
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      check($sformatf("lines n=%0d a=%0d k=%0d", n, a, k), {24'd0, lines_now()}, {24'd0, model_lines(k, n, a)});
      check($sformatf("cnt n=%0d a=%0d k=%0d", n, a, k), {24'd0, stroke_cnt}, 32'(model_cnt(k, n, a)));
      start   = (k < last_k) && ($urandom_range(0, 3) == 0);
      strokes = SW'($urandom_range(0, 7));
      if (n != 0 && k == a) abort = 1'b1;
      else if (k >= c) abort = 1'($urandom_range(0, 1));
      else abort = 1'b0;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    strokes = '0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_lines", {24'd0, lines_now()}, {24'd0, idle_lines});
    check("reset_cnt", {24'd0, stroke_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_lines", {24'd0, lines_now()}, {24'd0, idle_lines});

    run(1, 0);
    run(3, 0);
    run(0, 0);
    run(5, S + 1 + 6 * D + 3 * D);
    run(2, 2);
    run(2, S + 6 * D);
    for (int i = 0; i < 20; i++) begin
      int n = $urandom_range(0, 4);
      int a = 0;
      if (n != 0 && $urandom_range(0, 1) == 1) a = $urandom_range(1, S + 6 * D * n);
      run(n, a);
    end

    // Asynchronous reset during ph3 of the first stroke
    @(negedge clk);
    start   = 1'b1;
    strokes = SW'(2);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_ph3", {24'd0, lines_now()}, {24'd0, model_lines(10, 2, 0)});
    #1 rst = 1'b1;
    #1;
    check("async_rst_lines", {24'd0, lines_now()}, {24'd0, idle_lines});
    check("async_rst_cnt", {24'd0, stroke_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
